lsu_align_ctrl: RTL
===================

Name: lsu_align_ctrl

Overview:
- Sequential load/store data-path controller between the execute stage and a word-wide data memory port.
- Accepts one request at a time, aligns the address to a bus word, and generates byte enables and lane-shifted store data.
- Waits for the memory response, then extracts and sign- or zero-extends load data.
- Generalises byte/half/word formatting to any byte lane, XLEN of 32 or 64, and misalignment handling with error reporting.

Parameters:
- XLEN, 32, data/address width; legal values 32 and 64.
- NB, XLEN/8, bytes per bus word (derived; not to be overridden).

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset_n  input  1  synchronous active-low reset; one clock, no other clock domains.
- req_valid  input  1  request valid.
- req_ready  output  1  high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3: LB=000 LH=001 LW=010 LD=011 LBU=100 LHU=101 LWU=110; SB=000 SH=001 SW=010 SD=011.
- req_addr  input  XLEN  byte address.
- req_wdata  input  XLEN  store data, right-justified.
- mem_req_valid  output  1  bus request valid.
- mem_req_ready  input  1  bus accepts request.
- mem_we  output  1  bus write.
- mem_addr  output  XLEN  word-aligned address; low log2(NB) bits are 0.
- mem_be  output  NB  byte enables.
- mem_wdata  output  XLEN  lane-shifted store data.
- mem_rsp_valid  input  1  bus response, one pulse per accepted request; store ack or load data.
- mem_rdata  input  XLEN  load word.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_data  output  XLEN  extended load data; 0 for stores and errors.
- rsp_err  output  1  misaligned or illegal access; qualified by rsp_valid.

Behaviour:
- Reset (reset_n=0 at posedge):
  - state=IDLE.
  - mem_req_valid, rsp_valid, rsp_err = 0; rsp_data, mem_addr, mem_be, mem_wdata, mem_we = 0.
  - Reset mid-transaction abandons it; a later stray mem_rsp_valid in IDLE is ignored.
- States: IDLE, REQ, WAIT, REQ2, WAIT2, RESP.
- IDLE:
  - Request captured when req_valid & req_ready.
  - Legal request: compute offset = addr mod NB and size = 1/2/4/8 bytes; go to REQ.
  - Illegal request: go to RESP with err=1 and no bus activity. Illegal means:
    - funct3=111;
    - funct3 011 or 110 when XLEN=32;
    - store funct3 with bit2=1;
    - misaligned (see Optional Feature).
- REQ:
  - mem_req_valid=1; mem_addr, mem_be, mem_wdata, mem_we held stable until mem_req_ready.
  - Then go to WAIT.
  - mem_be = ((1<<size)-1) << offset, truncated to NB bits.
  - mem_wdata = req_wdata << (8*offset).
- WAIT:
  - On mem_rsp_valid, capture mem_rdata.
  - Go to REQ2 if a second beat is needed, else RESP.
  - mem_rsp_valid in the same cycle as mem_req_ready in REQ is not accepted; responses are only taken in WAIT/WAIT2.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - Loads: rsp_data = (rdata >> 8*offset) truncated to size, sign-extended (funct3 bit2=0) or zero-extended (bit2=1).
- Latency, zero-wait bus:
  - Accept at T, mem_req_valid at T+1, mem_rsp_valid at T+2, rsp_valid at T+3.
  - Error path: rsp_valid at T+1.
- No new request is accepted until the cycle after rsp_valid.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Without it:
  - Any access with addr mod size != 0 is misaligned → rsp_err=1, rsp_data=0, no bus request.
- With it:
  - A non-natural access fully inside one bus word (offset+size <= NB) is legal and uses one beat.
  - An access with offset+size > NB takes two beats:
    - Beat 1 (REQ/WAIT): word at aligned addr, be = lanes offset..NB-1.
    - Beat 2 (REQ2/WAIT2): word at aligned addr + NB, be = lanes 0..(offset+size-NB-1), wdata = req_wdata >> 8*(NB-offset).
  - Loads merge: {beat2, beat1} >> 8*offset, then extend.
  - Stores return rsp only after both acks.
  - Crossing the top of the address space wraps modulo 2^XLEN.
  - rsp_err is raised only for illegal funct3.

Test Plan:
- XLEN=32, LB addr 0x103, mem_rdata 0x80FF_1234 → mem_addr 0x100, mem_be 4'b1000, rsp_data 0xFFFF_FF80 at T+3.
- XLEN=32, SH addr 0x202, wdata 0x0000_ABCD → mem_be 4'b1100, mem_wdata 0xABCD_0000, mem_we=1, rsp_valid with err=0 after ack.
- mem_req_ready held low 3 cycles in REQ → mem_req_valid and the bus fields stay stable; rsp_valid is delayed 3 cycles; req_ready stays 0 throughout.
- XLEN=32, LW addr 0x101, no macro → rsp_valid at T+1, rsp_err=1, mem_req_valid never asserts. With macro, mem_rdata 0xDDCC_BBAA @0x100 and 0x1111_22EE @0x104 → two beats (be 4'b1110, 4'b0001), rsp_data 0xEEDD_CCBB.
- XLEN=32, funct3=011 (LD) → rsp_err=1, no bus activity; XLEN=64 LD addr 0x8 → mem_be 8'hFF, full 64-bit passthrough.
- reset_n driven low while in WAIT → next cycle state IDLE, req_ready=1, all outputs 0; a late mem_rsp_valid produces no rsp_valid.

Source files
------------

// File: rtl/lsu_align_ctrl_if.sv
// Bundle of execute-side request/response and data-memory bus signals for lsu_align_ctrl.
// slave is the controller's view; master is the view of whoever drives it.
interface lsu_align_ctrl_if #(
  parameter int XLEN = 32
);
  localparam int NB = XLEN / 8;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [NB-1:0]   mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rdata;

  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output req_ready, mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
    output rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  req_ready, mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
    input  rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/lsu_align_ctrl.sv
// Load/store alignment controller: byte enables, lane shifting and load extension for a word-wide bus.
// Define LSU_MISALIGN_SPLIT_EN to accept unaligned accesses, splitting word-crossing ones into two beats.
module lsu_align_ctrl #(
  parameter int XLEN = 32
) (
  input logic             clock,
  input logic             reset_n,
  lsu_align_ctrl_if.slave bus
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, REQ2, WAIT2, RESP} state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic            r_we;
  logic [2:0]      r_f3;
  logic [OFFW-1:0] r_off;
  logic            r_two;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;
  logic [NB-1:0]   r_mem_be;
  logic            r_mem_we;
  logic [XLEN-1:0] r_wdata2;
  logic [NB-1:0]   r_be2;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_rsp_data;
  logic            r_rsp_err;

  logic [OFFW-1:0]   w_off;
  logic [3:0]        w_size;
  logic [XLEN-1:0]   w_addr_al;
  logic              w_illegal_f3;
  logic              w_misalign;
  logic              w_two;
  logic              w_legal;
  logic [2*NB-1:0]   w_be_full;
  logic [2*XLEN-1:0] w_wd_full;
  logic              w_req_ready;
  logic              w_mem_req_valid;
  logic              w_rsp_valid;

  assign w_off     = bus.req_addr[OFFW-1:0];
  assign w_size    = 4'd1 << bus.req_funct3[1:0];
  assign w_addr_al = {bus.req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};

  assign w_illegal_f3 = (bus.req_funct3 == 3'b111)
                     || (bus.req_we && bus.req_funct3[2])
                     || ((XLEN == 32) && ((bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110)));

  // Double-width enables/data: the low half is beat 1, the spill into the high half is beat 2.
  assign w_be_full = (((2*NB)'(1) << w_size) - (2*NB)'(1)) << w_off;
  assign w_wd_full = {{XLEN{1'b0}}, bus.req_wdata} << {w_off, 3'b000};

`ifdef LSU_MISALIGN_SPLIT_EN
  assign w_misalign = 1'b0;
  assign w_two      = ((OFFW+2)'(w_off) + (OFFW+2)'(w_size)) > (OFFW+2)'(NB);
`else
  assign w_misalign = |(w_off & OFFW'(w_size - 4'd1));
  assign w_two      = 1'b0;
`endif

  assign w_legal = !w_illegal_f3 && !w_misalign;

  function automatic logic [XLEN-1:0] extend(input logic [2*XLEN-1:0] merged,
                                             input logic [OFFW-1:0]   off,
                                             input logic [2:0]        f3);
    logic [XLEN-1:0] v;
    v = XLEN'(merged >> {off, 3'b000});
    case (f3[1:0])
      2'b00:   extend = f3[2] ? XLEN'(v[7:0])  : XLEN'($signed(v[7:0]));
      2'b01:   extend = f3[2] ? XLEN'(v[15:0]) : XLEN'($signed(v[15:0]));
      2'b10:   extend = f3[2] ? XLEN'(v[31:0]) : XLEN'($signed(v[31:0]));
      default: extend = v;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next    = r_state;
    w_req_ready     = 1'b0;
    w_mem_req_valid = 1'b0;
    w_rsp_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) w_state_next = w_legal ? REQ : RESP;
      end
      REQ: begin
        w_mem_req_valid = 1'b1;
        if (bus.mem_req_ready) w_state_next = WAIT;
      end
      WAIT:  if (bus.mem_rsp_valid) w_state_next = r_two ? REQ2 : RESP;
      REQ2: begin
        w_mem_req_valid = 1'b1;
        if (bus.mem_req_ready) w_state_next = WAIT2;
      end
      WAIT2: if (bus.mem_rsp_valid) w_state_next = RESP;
      RESP: begin
        w_rsp_valid  = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_we        <= 1'b0;
      r_f3        <= '0;
      r_off       <= '0;
      r_two       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_mem_we    <= 1'b0;
      r_wdata2    <= '0;
      r_be2       <= '0;
      r_lo        <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we       <= bus.req_we;
            r_f3       <= bus.req_funct3;
            r_off      <= w_off;
            r_rsp_data <= '0;
            r_rsp_err  <= !w_legal;
            if (w_legal) begin
              r_two       <= w_two;
              r_mem_addr  <= w_addr_al;
              r_mem_be    <= w_be_full[NB-1:0];
              r_mem_wdata <= w_wd_full[XLEN-1:0];
              r_mem_we    <= bus.req_we;
              r_be2       <= w_be_full[2*NB-1:NB];
              r_wdata2    <= w_wd_full[2*XLEN-1:XLEN];
            end
          end
        end
        WAIT: begin
          if (bus.mem_rsp_valid) begin
            if (r_two) begin
              r_lo        <= bus.mem_rdata;
              r_mem_addr  <= r_mem_addr + XLEN'(NB);
              r_mem_be    <= r_be2;
              r_mem_wdata <= r_wdata2;
            end else if (!r_we) begin
              r_rsp_data <= extend({{XLEN{1'b0}}, bus.mem_rdata}, r_off, r_f3);
            end
          end
        end
        WAIT2: begin
          if (bus.mem_rsp_valid && !r_we)
            r_rsp_data <= extend({bus.mem_rdata, r_lo}, r_off, r_f3);
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready     = w_req_ready;
  assign bus.mem_req_valid = w_mem_req_valid;
  assign bus.mem_we        = r_mem_we;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_be        = r_mem_be;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.rsp_valid     = w_rsp_valid;
  assign bus.rsp_data      = r_rsp_data;
  assign bus.rsp_err       = r_rsp_err;
endmodule
